// File: rtl/gauss_pkg.sv
// Shared types and helpers for the Gaussian stream sequencer.
// Optional bypass feature is enabled by defining GAUSS_BYPASS_EN.
package gauss_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ROW,
        PAD,
        FLUSH,
        FRESET
    } gauss_state_e;

    // Bits needed to hold the values 0..n-1.
    function automatic int gauss_cw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Output FIFO writes produced by one full frame.
    function automatic int frame_writes(input int w, input int h,
                                        input int p, input int f);
        return h * (w + p) + f;
    endfunction

endpackage

// File: rtl/gauss_stream_seq_if.sv
// Stream bundle between down-sampler, filter core and up-sampler.
// master: the sequencer; slave: the surrounding pipeline.
interface gauss_stream_seq_if #(
    parameter int PIX_W = 8
);
    logic             valid;
    logic [PIX_W-1:0] din;
    logic             rd_en_down;
    logic [PIX_W-1:0] filt_din;
    logic             filt_en;
    logic             filt_rst;
    logic [PIX_W-1:0] filt_dout;
    logic             rd_en_up;
    logic [PIX_W-1:0] dout;
    logic             valid_out;
    logic             empty;
    logic             frame_done;

    modport master (
        input  valid, din, filt_dout, rd_en_up,
        output rd_en_down, filt_din, filt_en, filt_rst,
        output dout, valid_out, empty, frame_done
    );

    modport slave (
        output valid, din, filt_dout, rd_en_up,
        input  rd_en_down, filt_din, filt_en, filt_rst,
        input  dout, valid_out, empty, frame_done
    );
endinterface

// File: rtl/gauss_out_fifo.sv
// Single-clock output FIFO with count-based full/empty.
// Read data and its valid flag are registered.
module gauss_out_fifo #(
    parameter int PIX_W = 8,
    parameter int DEPTH = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [PIX_W-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [PIX_W-1:0]       dout,
    output logic                   valid_out,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;

    logic [PIX_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, wp_d;
    logic [AW-1:0]    rp_q, rp_d;
    logic [NW-1:0]    count_q, count_d;
    logic [PIX_W-1:0] dout_q, dout_d;
    logic             vo_q, vo_d;
    logic             wr_ok, rd_ok;

    // Accept decisions use the registered count only.
    always_comb begin
        wr_ok   = wr_en & (count_q != NW'(DEPTH));
        rd_ok   = rd_en & (count_q != '0);
        wp_d    = wr_ok ? wp_q + AW'(1) : wp_q;
        rp_d    = rd_ok ? rp_q + AW'(1) : rp_q;
        dout_d  = rd_ok ? mem_q[rp_q] : dout_q;
        vo_d    = rd_ok;
        count_d = count_q;
        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + NW'(1);
            2'b01:   count_d = count_q - NW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage array, written on accepted pushes.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wp_q] <= wr_data;
        end
    end

    // Pointer, count and read-port registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            dout_q  <= '0;
            vo_q    <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            dout_q  <= dout_d;
            vo_q    <= vo_d;
        end
    end

    assign dout      = dout_q;
    assign valid_out = vo_q;
    assign empty     = (count_q == '0);
    assign count     = count_q;

endmodule

// File: rtl/gauss_stream_seq.sv
// Row/pad/flush sequencer feeding the Gaussian core, with output FIFO.
// Define GAUSS_BYPASS_EN to add the bypass input (FIFO takes filt_din).
module gauss_stream_seq
    import gauss_pkg::*;
#(
    parameter int PIX_W        = 8,
    parameter int IMG_W        = 400,
    parameter int IMG_H        = 300,
    parameter int PAD_COLS     = 2,
    parameter int FLUSH_CYCLES = 804,
    parameter int OUT_DEPTH    = 1024
) (
    input logic clk,
    input logic rst_n,
`ifdef GAUSS_BYPASS_EN
    input logic bypass,
`endif
    gauss_stream_seq_if.master bus
);
    localparam int CW = gauss_cw(IMG_W);
    localparam int RW = gauss_cw(IMG_H);
    localparam int PW = gauss_cw(PAD_COLS);
    localparam int FW = gauss_cw(FLUSH_CYCLES);
    localparam int NW = $clog2(OUT_DEPTH) + 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [PW-1:0] PAD_LAST = PW'(PAD_COLS - 1);
    localparam logic [FW-1:0] FL_LAST  = FW'(FLUSH_CYCLES - 1);

    gauss_state_e     state_q, state_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [PW-1:0]    pad_q, pad_d;
    logic [FW-1:0]    fl_q, fl_d;
    logic [NW-1:0]    count;
    logic             space;
    logic             adv;
    logic             pop;
    logic             frst;
    logic             fdone;
    logic [PIX_W-1:0] fdin;
    logic [PIX_W-1:0] wr_data;

    assign space = (count != NW'(OUT_DEPTH));

    // Next-state, counters and filter-side outputs; all idle in reset.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        pad_d   = pad_q;
        fl_d    = fl_q;
        adv     = 1'b0;
        pop     = 1'b0;
        fdin    = '0;
        frst    = ~rst_n;
        fdone   = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                IDLE, ROW: begin
                    fdin = bus.din;
                    adv  = bus.valid & space;
                    pop  = adv;
                    if (adv) begin
                        if (col_q == COL_LAST) begin
                            col_d   = '0;
                            state_d = PAD;
                        end else begin
                            col_d   = col_q + CW'(1);
                            state_d = ROW;
                        end
                    end
                end
                PAD: begin
                    adv = space;
                    if (adv) begin
                        if (pad_q == PAD_LAST) begin
                            pad_d = '0;
                            if (row_q == ROW_LAST) begin
                                row_d   = '0;
                                state_d = FLUSH;
                            end else begin
                                row_d   = row_q + RW'(1);
                                state_d = ROW;
                            end
                        end else begin
                            pad_d = pad_q + PW'(1);
                        end
                    end
                end
                FLUSH: begin
                    adv = space;
                    if (adv) begin
                        if (fl_q == FL_LAST) begin
                            fl_d    = '0;
                            state_d = FRESET;
                        end else begin
                            fl_d = fl_q + FW'(1);
                        end
                    end
                end
                FRESET: begin
                    frst    = 1'b1;
                    fdone   = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef GAUSS_BYPASS_EN
    logic byp_q, byp_d;

    // Bypass is latched while idle; the first accept already uses it.
    always_comb begin
        byp_d   = (state_q == IDLE) ? bypass : byp_q;
        wr_data = byp_d ? fdin : bus.filt_dout;
    end

    // Bypass mode register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byp_q <= 1'b0;
        end else begin
            byp_q <= byp_d;
        end
    end
`else
    assign wr_data = bus.filt_dout;
`endif

    // Sequencer state and position counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            pad_q   <= '0;
            fl_q    <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            pad_q   <= pad_d;
            fl_q    <= fl_d;
        end
    end

    gauss_out_fifo #(
        .PIX_W (PIX_W),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (adv),
        .wr_data   (wr_data),
        .rd_en     (bus.rd_en_up),
        .dout      (bus.dout),
        .valid_out (bus.valid_out),
        .empty     (bus.empty),
        .count     (count)
    );

    assign bus.rd_en_down = pop;
    assign bus.filt_din   = fdin;
    assign bus.filt_en    = adv;
    assign bus.filt_rst   = frst;
    assign bus.frame_done = fdone;

endmodule

// File: doc/gauss_stream_seq.md
Name: gauss_stream_seq

Overview:
- Parametrised sequencer between the down-sampler FIFO and the Gaussian filter core.
- Pulls pixels row by row, inserts PAD_COLS zero pixels after each row, flushes the filter pipeline with FLUSH_CYCLES zeros at end of frame, then pulses the filter reset.
- Captures every filter output into an internal output FIFO read by the up-sampler.
- Adds full backpressure: the filter and the input pop stall whenever the output FIFO is full.

Parameters:
- PIX_W, 8, pixel width in bits.
- IMG_W, 400, pixels per row.
- IMG_H, 300, rows per frame.
- PAD_COLS, 2, zero pixels inserted after each row.
- FLUSH_CYCLES, 804, zero pixels fed after the last row's padding.
- OUT_DEPTH, 1024, output FIFO entries (power of 2, >=4).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- valid  in  1  down-sampler FIFO has data.
- din  in  PIX_W  down-sampler data.
- rd_en_down  out  1  pop the down-sampler FIFO.
- filt_din  out  PIX_W  pixel to the filter core.
- filt_en  out  1  filter clock-enable (advance).
- filt_rst  out  1  filter reset.
- filt_dout  in  PIX_W  filter core output (registered inside the core).
- rd_en_up  in  1  up-sampler pop.
- dout  out  PIX_W  output FIFO data (registered).
- valid_out  out  1  dout valid, one cycle after an accepted rd_en_up.
- empty  out  1  output FIFO empty.
- frame_done  out  1  one-cycle pulse in FRESET.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; all counters 0; output FIFO emptied.
  - rd_en_down=0, filt_en=0, filt_din=0, valid_out=0, empty=1, dout=0, frame_done=0.
  - filt_rst=1 while rst_n=0.
  - Reset mid-frame discards all progress; the next accepted pixel is column 0 of row 0.
- space = (fifo_count != OUT_DEPTH).
- adv = filt_en. Whenever adv=1, filt_dout is written to the output FIFO in the same cycle. There is no other write source.
- States:
  - IDLE (frame not started): adv = valid & space; go to ROW when adv.
  - ROW: adv = valid & space; rd_en_down = adv; filt_din = din.
    - valid=0 or full stalls the filter (no write, counters hold).
    - Each adv increments col; at col==IMG_W-1 with adv, col<=0 and go to PAD.
  - PAD: filt_din=0; adv = space; pad counter counts PAD_COLS advances.
    - Then row++ and go to ROW.
    - If row==IMG_H-1, row<=0 and go to FLUSH instead.
  - FLUSH: filt_din=0; adv = space; after FLUSH_CYCLES advances go to FRESET.
  - FRESET: one cycle; filt_rst=1, frame_done=1, adv=0, no write; go to IDLE.
  - IDLE and ROW share the accept logic: the first accepted pixel from IDLE counts as col 0.
  - rd_en_down is 0 in every state except ROW/IDLE-accept.
- filt_rst = ~rst_n | (state==FRESET).
- Writes per frame = IMG_H*(IMG_W+PAD_COLS) + FLUSH_CYCLES.
- Output FIFO:
  - Simultaneous write and read when full: the read frees space the next cycle only; adv uses the registered count.
  - rd_en_up when empty is ignored (valid_out=0).
  - Simultaneous read and write when empty: write lands, read is ignored.
- Counters are $clog2-sized and never wrap past their terminal values.

Optional Feature:
- GAUSS_BYPASS_EN:
  - Defined: adds input port bypass (1). When bypass=1, the FIFO write data is the current filt_din instead of filt_dout. Sequencing, padding and flush are unchanged.
  - bypass is sampled only in IDLE and held for the frame.
  - Undefined: no port; the FIFO always takes filt_dout.

Decomposition:
- Package gauss_pkg: state enum (IDLE, ROW, PAD, FLUSH, FRESET), the write-count-per-frame constant function, and the clog2 width helper.
- One sub-module: gauss_out_fifo (single-clock, OUT_DEPTH x PIX_W, count-based full/empty, registered dout/valid).

Test Plan (IMG_W=4, IMG_H=2, PAD_COLS=2, FLUSH_CYCLES=3, OUT_DEPTH=8 unless stated):
- Continuous valid, rd_en_up=1, filt_dout=filt_din delayed 1 -> exactly 15 FIFO writes. filt_din sequence: 4 pixels, 0,0, 4 pixels, 0,0,0,0,0. frame_done pulses once, coincident with filt_rst.
- Hold rd_en_up=0 -> after 8 writes filt_en=0, rd_en_down=0, no pixels lost. Release -> remaining 7 writes complete, total 15.
- valid toggled 1/0 each cycle in ROW -> filt_en tracks valid. Pad cycles proceed without valid. Column count is exact.
- rst_n=0 for one cycle after pixel 6 -> empty=1, filt_rst=1. A new frame produces 15 writes starting at col 0.
- rd_en_up while empty -> valid_out stays 0, no count underflow. Write and read in the same cycle at count 3 -> count stays 3.
- GAUSS_BYPASS_EN with bypass=1, pixels 1..8 -> dout stream 1,2,3,4,0,0,5,6,7,8,0,0,0,0,0.
